shift_stream_controller: RTL and testbench

//  Sequential front end for the 16-bit RightBarrelShifter datapath in the UniversalShifter block.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_stream_controller_shifter.sv | 22 ++
 rtl/shift_stream_controller.sv | 134 +++++++++++++
 tb/tb_shift_stream_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types, constants and helpers for the shift stream controller.
package shift_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    PASS2 = 2'd2
  } state_e;

  // Captured request payload
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [1:0]       op;
  } req_t;

  // Bit reversal used to turn the right shifter into a left shifter
  function automatic logic [WIDTH-1:0] bitrev16(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stream_controller_shifter.sv
// Combinational 16-bit logical right barrel shifter (log2 stages).
module RightBarrelShifter
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // One stage per amount bit: shift by 1, 2, 4, 8
  always_comb begin
    s0       = amt[0] ? (in_data >> 1) : in_data;
    s1       = amt[1] ? (s0 >> 2)      : s0;
    s2       = amt[2] ? (s1 >> 4)      : s1;
    out_data = amt[3] ? (s2 >> 8)      : s2;
  end

endmodule

// File: rtl/shift_stream_controller.sv
// Valid/ready front end driving one shared right barrel shifter for LSR/ASR/LSL/ROR.
module shift_stream_controller
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             in_ready_c;
  logic             retire_c;
  logic             single_pass_c;
  logic             neg_c;
  logic [WIDTH-1:0] sh_in_c;
  logic [SHW-1:0]   sh_amt_c;
  logic [WIDTH-1:0] sh_out_c;
  logic [WIDTH-1:0] result_c;

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign retire_c      = !out_valid_q || out_ready;
  assign single_pass_c = !((req_q.op == OP_ROR) && (req_q.amt != SHW'(0)));
  assign neg_c         = (req_q.op == OP_ASR) && req_q.data[WIDTH-1];

  // Pre-shift mapping: inversion for negative ASR, reversal for LSL and ROR second pass
  always_comb begin
    sh_in_c  = req_q.data;
    sh_amt_c = req_q.amt;
    if ((state_q == PASS2) || (req_q.op == OP_LSL)) begin
      sh_in_c = bitrev16(req_q.data);
    end else if (neg_c) begin
      sh_in_c = ~req_q.data;
    end
    if (state_q == PASS2) begin
      sh_amt_c = (~req_q.amt) + SHW'(1);
    end
  end

  RightBarrelShifter u_shifter (
    .in_data  (sh_in_c),
    .amt      (sh_amt_c),
    .out_data (sh_out_c)
  );

  // Post-shift mapping: undo reversal/inversion, merge ROR halves
  always_comb begin
    result_c = sh_out_c;
    if (state_q == PASS2) begin
      result_c = part_q | bitrev16(sh_out_c);
    end else if (req_q.op == OP_LSL) begin
      result_c = bitrev16(sh_out_c);
    end else if (neg_c) begin
      result_c = ~sh_out_c;
    end
  end

  // Next-state, handshake and output-stage update
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    part_d      = part_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    in_ready_c  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
      end
      EXEC: begin
        if (!single_pass_c) begin
          part_d  = result_c;
          state_d = PASS2;
        end else if (retire_c) begin
          out_valid_d = 1'b1;
          out_data_d  = result_c;
          in_ready_c  = 1'b1;
          state_d     = IDLE;
        end
      end
      PASS2: begin
        if (retire_c) begin
          out_valid_d = 1'b1;
          out_data_d  = result_c;
          in_ready_c  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_valid && in_ready_c) begin
      req_d.data = in_data;
      req_d.amt  = in_amt;
      req_d.op   = in_op;
      state_d    = EXEC;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      part_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      part_q      <= part_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_shift_stream_controller.sv
// Self-checking bench for shift_stream_controller: directed vectors plus a queue scoreboard.
module tb_shift_stream_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = '0;

  shift_stream_controller dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of each op in plain arithmetic
  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] amt, input logic [1:0] op);
    logic [31:0] x;
    x = {16'h0000, a};
    case (op)
      2'b00:   return a >> amt;
      2'b01:   return 16'($signed(a) >>> amt);
      2'b10:   return a << amt;
      default: return 16'((x >> amt) | (x << (16 - int'(amt))));
    endcase
  endfunction

  // Scoreboard: record accepts, check every output transfer and output stability under stall
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_amt, in_op));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("scoreboard", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      prev_hold <= out_valid && !out_ready;
      prev_data <= out_data;
    end
  end

  // Present a request until it is accepted; returns just after the accepting edge
  task automatic drive(input logic [15:0] a, input logic [3:0] amt, input logic [1:0] op);
    int n;
    in_valid = 1'b1;
    in_data  = a;
    in_amt   = amt;
    in_op    = op;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single request with out_ready=1, checking exact latency and value
  task automatic run_one(input string name, input logic [15:0] a, input logic [3:0] amt,
                         input logic [1:0] op, input logic [15:0] exp, input int lat);
    drive(a, amt, op);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check({name, "_early"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    @(negedge clk);
    check({name, "_drain"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] va[8] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h00FF, 16'hA5A5, 16'h8000, 16'h0F0F, 16'hC003};
  logic [3:0]  vm[8] = '{4'd4, 4'd1, 4'd8, 4'd0, 4'd15, 4'd7, 4'd3, 4'd2};
  logic [1:0]  vo[8] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b1;

    // Model pinned to hand-computed values
    check("model_lsr", 32'(model(16'hF0F0, 4'd4, 2'b00)), 32'h0F0F);
    check("model_asr", 32'(model(16'h8000, 4'd15, 2'b01)), 32'hFFFF);
    check("model_lsl", 32'(model(16'h0001, 4'd15, 2'b10)), 32'h8000);
    check("model_ror", 32'(model(16'h1234, 4'd4, 2'b11)), 32'h4123);
    check("model_ror0", 32'(model(16'h1234, 4'd0, 2'b11)), 32'h1234);

    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    run_one("lsr", 16'hF0F0, 4'd4, 2'b00, 16'h0F0F, 1);
    run_one("asr_neg", 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1);
    run_one("asr_pos", 16'h7FFF, 4'd3, 2'b01, 16'h0FFF, 1);
    run_one("lsl15", 16'h0001, 4'd15, 2'b10, 16'h8000, 1);
    run_one("lsl0", 16'hABCD, 4'd0, 2'b10, 16'hABCD, 1);

    // ROR two-pass: in_ready rises in PASS2 because the output stage is free
    drive(16'h1234, 4'd4, 2'b11);
    @(negedge clk);
    check("ror_p1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("ror_p2_valid", 32'(out_valid), 32'd0);
    check("ror_p2_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("ror_valid", 32'(out_valid), 32'd1);
    check("ror_data", 32'(out_data), 32'h4123);
    @(posedge clk);
    #1;
    run_one("ror0", 16'h1234, 4'd0, 2'b11, 16'h1234, 1);

    // Backpressure: two accepted, third held, then three results in order
    out_ready = 1'b0;
    drive(16'h8000, 4'd1, 2'b00);
    drive(16'h00F0, 4'd4, 2'b00);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_amt   = 4'd8;
    in_op    = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_held", 32'(out_data), 32'h4000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_r1", 32'(out_data), 32'h4000);
    check("bp_accept3", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_r2_valid", 32'(out_valid), 32'd1);
    check("bp_r2", 32'(out_data), 32'h000F);
    @(negedge clk);
    check("bp_r3_valid", 32'(out_valid), 32'd1);
    check("bp_r3", 32'(out_data), 32'h00FF);
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset during ROR second pass
    drive(16'h1234, 4'd4, 2'b11);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_one("post_rst", 16'h0100, 4'd8, 2'b00, 16'h0001, 1);

    // Mixed ops under random backpressure; scoreboard checks order and values
    fork
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int r = 0; r < 3; r++) begin
          for (int i = 0; i < 8; i++) drive(va[i], vm[i], vo[i]);
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 20 && (exp_q.size() != 0 || out_valid); n++) @(negedge clk);
    check("drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("final_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
